flit_distributor: RTL
=====================

# flit_distributor

Wormhole 1-to-N flit distributor: the demultiplexing counterpart of the N-to-1 reductor. Accepts one flit stream, reads the destination field of each head/single flit, and steers that flit and all following body/tail flits of the same packet to one of N output ports. Sits at a router input stage, feeding per-port reductors. Buffers two flits at the input and one flit per output so back-pressure never needs a combinational path from output to input.

## Interface
- N, 8, number of output ports; power of two, 2..16
- DST_POS, from package, MSB position of the destination field in a head/single flit
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- in  input  FLIT_SIZE  incoming flit
- in_valid  input  1  `in` holds a flit
- in_avail  output  1  block accepts a flit this cycle
- out  output  FLIT_SIZE*N  flat, port i at bits [FLIT_SIZE*i +: FLIT_SIZE]
- out_valid  output  N  port i holds a flit
- out_avail  input  N  downstream of port i accepts this cycle
- drop_cnt  output  16  saturating count of discarded flits

## Operation
- Transfer rules: input transfer when in_valid && in_avail; output transfer on port i when out_valid[i] && out_avail[i].
- Flit type is in[FLIT_SIZE-1 -: HEADER_LEN]: HEAD_FLIT, BODY_FLIT, TAIL_FLIT, SINGLE_FLIT.
- Port select: p = low log2(N) bits of flit[DST_POS -: DST_LEN]; higher destination bits are ignored.
- Input buffer: 2-entry FIFO. in_avail = rst high && FIFO not full; it depends only on registered count, never on out_avail. A push while full is impossible by construction.
- FSM, states IDLE and ROUTE, with a lock register lock_port. The FSM evaluates the FIFO head flit each cycle; the flit pops only when its target output register is empty or is draining that cycle.
- IDLE:
  - HEAD: forward to p, lock_port <= p, go to ROUTE.
  - SINGLE: forward to p, stay IDLE.
  - BODY or TAIL: pop without forwarding, drop_cnt += 1, stay IDLE.
- ROUTE:
  - BODY: forward to lock_port, stay.
  - TAIL: forward to lock_port, go to IDLE.
  - HEAD (missing tail): treat as a new packet. Forward to the new p, relock, stay in ROUTE. Not counted.
  - SINGLE: forward to p, go to IDLE.
- Output registers hold data stable while out_valid[i] && !out_avail[i]. A port can accept a new flit in the same cycle it drains.
- drop_cnt saturates at 16'hFFFF.
- Reset, asynchronous, any time including mid-packet: FIFO empty, all out_valid = 0, out = 0, state IDLE, lock_port = 0, drop_cnt = 0, in_avail = 0 while rst is low. After reset, remaining flits of an interrupted packet arrive in IDLE and are dropped and counted.

## Timing
- Latency: a flit accepted at edge t appears on out at t+2 if the target port is free. One cycle is the FIFO, one is the output register.
- Throughput: 1 flit/cycle sustained within a packet and across back-to-back packets to different free ports.
- A blocked port stalls the FIFO head. This is head-of-line blocking; flits for other ports behind it wait too.
- in_avail is 1 in the first cycle after rst deasserts.
- out_avail may toggle freely; out_valid never drops without a transfer.

## Structure
- Shared package, alongside the reductor constants: FLIT_SIZE, HEADER_LEN, HEAD_FLIT/BODY_FLIT/TAIL_FLIT/SINGLE_FLIT, DST_POS, DST_LEN, and a flit-type enum.
- Sub-module flit_skid_fifo: 2-entry FIFO with parameter WIDTH, ports push/pop/full/empty, async active-low reset.
- The FSM, lock register, output registers and counter stay in flit_distributor.

## Test plan
- Packet of HEAD(dst=3), BODY, BODY, TAIL, all out_avail=1: the four flits appear on port 3 only, at cycles t+2..t+5; all other out_valid stay 0.
- SINGLE(dst=5) followed by SINGLE(dst=1) back-to-back: port 5 valid at t+2, port 1 at t+3, in_avail held 1 throughout.
- Packet to port 2 with out_avail[2]=0 for 6 cycles: in_avail drops after 3 accepted flits (FIFO 2 + output 1), port 2 data stays stable, and the stream resumes 1/cycle after release with no loss or reorder.
- BODY and TAIL arriving in IDLE: neither flit is forwarded, drop_cnt goes 0→2; a following HEAD(dst=7) routes normally.
- Reset asserted after HEAD(dst=4) and one BODY: all out_valid=0 immediately (asynchronous); post-reset BODY, TAIL are dropped (drop_cnt=2); a new HEAD(dst=0) routes to port 0.
- HEAD(dst=6), BODY, then HEAD(dst=1) without a tail: the second packet goes to port 1, drop_cnt unchanged.

Source files
------------

// File: rtl/flit_distributor_pkg.sv
// Flit format constants shared by the wormhole distributor and reductor.
package flit_distributor_pkg;

   localparam int FLIT_SIZE  = 34;
   localparam int HEADER_LEN = 2;
   localparam int DST_LEN    = 4;
   localparam int DST_POS    = FLIT_SIZE - HEADER_LEN - 1;

   localparam logic [HEADER_LEN-1:0] BODY_FLIT   = 2'b00;
   localparam logic [HEADER_LEN-1:0] HEAD_FLIT   = 2'b01;
   localparam logic [HEADER_LEN-1:0] TAIL_FLIT   = 2'b10;
   localparam logic [HEADER_LEN-1:0] SINGLE_FLIT = 2'b11;

   typedef enum logic [HEADER_LEN-1:0] {
      FT_BODY   = BODY_FLIT,
      FT_HEAD   = HEAD_FLIT,
      FT_TAIL   = TAIL_FLIT,
      FT_SINGLE = SINGLE_FLIT
   } flit_type_e;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ROUTE = 1'b1
   } dist_state_e;

endpackage

// File: rtl/flit_distributor_skid_fifo.sv
// Two-entry input FIFO; full/empty come straight from the registered count.
module flit_skid_fifo
   import flit_distributor_pkg::*;
#(
   parameter int WIDTH = FLIT_SIZE
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [2];
   logic             wr_ptr;
   logic             rd_ptr;
   logic [1:0]       count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

   assign dout  = mem[rd_ptr];
   assign full  = (count == 2'd2);
   assign empty = (count == 2'd0);

endmodule

// File: rtl/flit_distributor.sv
// Wormhole 1-to-N flit distributor: steers each packet to the port named in its head flit.
//
//  state    | meaning
//  ---------+--------------------------------------------------------------
//  ST_IDLE  | between packets; body/tail flits seen here are dropped
//  ST_ROUTE | inside a packet; body/tail flits follow lock_port
module flit_distributor
   import flit_distributor_pkg::*;
#(
   parameter int N = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [FLIT_SIZE-1:0]   in,
   input  logic                   in_valid,
   output logic                   in_avail,
   output logic [FLIT_SIZE*N-1:0] out,
   output logic [N-1:0]           out_valid,
   input  logic [N-1:0]           out_avail,
   output logic [15:0]            drop_cnt
);

   localparam int PW = $clog2(N);

   dist_state_e          state;
   dist_state_e          state_nxt;
   logic [PW-1:0]        lock_port;
   logic [PW-1:0]        lock_nxt;

   logic [FLIT_SIZE-1:0] head;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 fifo_pop;
   logic                 fifo_push;

   flit_type_e           head_type;
   logic [PW-1:0]        head_port;
   logic [PW-1:0]        fwd_port;
   logic                 want_fwd;
   logic                 drop_req;
   logic                 port_free;
   logic                 load;

   logic [FLIT_SIZE-1:0] out_q [N];

   assign in_avail  = rst && !fifo_full;
   assign fifo_push = in_valid && in_avail;

   flit_skid_fifo #(
      .WIDTH (FLIT_SIZE)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .din   (in),
      .pop   (fifo_pop),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Only the low log2(N) bits of the destination field select a port.
   assign head_type = flit_type_e'(head[FLIT_SIZE-1 -: HEADER_LEN]);
   assign head_port = head[DST_POS-DST_LEN+1 +: PW];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         lock_port <= '0;
      end else begin
         state     <= state_nxt;
         lock_port <= lock_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      lock_nxt  = lock_port;
      want_fwd  = 1'b0;
      drop_req  = 1'b0;
      fwd_port  = head_port;
      if (!fifo_empty) begin
         case (head_type)
            FT_HEAD, FT_SINGLE: want_fwd = 1'b1;
            default: begin
               if (state == ST_ROUTE) begin
                  want_fwd = 1'b1;
                  fwd_port = lock_port;
               end else begin
                  drop_req = 1'b1;
               end
            end
         endcase
      end
      port_free = !out_valid[fwd_port] || out_avail[fwd_port];
      load      = want_fwd && port_free;
      fifo_pop  = drop_req || load;
      // A dropped body leaves IDLE unchanged; a dropped tail re-selects IDLE.
      if (fifo_pop) begin
         case (head_type)
            FT_HEAD: begin
               state_nxt = ST_ROUTE;
               lock_nxt  = head_port;
            end
            FT_BODY: state_nxt = state;
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid <= '0;
         for (int i = 0; i < N; i++) begin
            out_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (load && fwd_port == PW'(i)) begin
               out_q[i]     <= head;
               out_valid[i] <= 1'b1;
            end else if (out_avail[i]) begin
               out_valid[i] <= 1'b0;
            end
         end
      end
   end

   for (genvar g = 0; g < N; g++) begin : g_out
      assign out[FLIT_SIZE*g +: FLIT_SIZE] = out_q[g];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         drop_cnt <= 16'd0;
      end else if (drop_req && drop_cnt != 16'hFFFF) begin
         drop_cnt <= drop_cnt + 16'd1;
      end
   end

endmodule
